// File: rtl/imem_prog_encoder_pkg.sv
// Types shared by the instruction-memory program loader and its encoder.
package LoaderPkg;

   // Instruction format selector; the value 2'd3 is reserved and always illegal.
   typedef enum logic [1:0] {
      FmtR = 2'd0,
      FmtI = 2'd1,
      FmtJ = 2'd2
   } FmtType;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StWrite = 3'd2,
      StDone  = 3'd3,
      StErr   = 3'd4
   } LoaderState;

endpackage

// File: rtl/opcodes_pkg.sv
// MIPS primary opcodes shared by the single-cycle control decoder and the
// program loader; only the opcodes that decoder accepts are listed here.
package Opcodes;

   localparam logic [5:0] OpRType = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAddiu = 6'h09;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;

endpackage

// File: rtl/imem_prog_encoder_instr_pack.sv
// Combinational MIPS word packer: builds the 32-bit word for R/I/J formats and
// flags whether the format/opcode pair is one the control decoder accepts.
module instr_pack
   import LoaderPkg::*;
   import Opcodes::*;
(
   input  logic [1:0]  i_fmt,
   input  logic [5:0]  i_op,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_shamt,
   input  logic [5:0]  i_funct,
   input  logic [15:0] i_imm,
   input  logic [25:0] i_target,
   output logic [31:0] o_word,
   output logic        o_legal
);

   always_comb begin
      o_word  = '0;
      o_legal = 1'b0;
      case (i_fmt)
         FmtR: begin
            o_word  = {i_op, i_rs, i_rt, i_rd, i_shamt, i_funct};
            o_legal = (i_op == OpRType);
         end
         FmtI: begin
            o_word  = {i_op, i_rs, i_rt, i_imm};
            o_legal = (i_op == OpLw)   || (i_op == OpSw)   || (i_op == OpBeq) ||
                      (i_op == OpAddi) || (i_op == OpAddiu);
         end
         FmtJ: begin
            o_word  = {i_op, i_target};
            o_legal = (i_op == OpJ);
         end
         default: begin
            o_word  = '0;
            o_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/imem_prog_encoder.sv
// Program loader: encodes streamed instruction fields, writes them into
// instruction memory one word per two cycles, and holds the CPU in reset meanwhile.
module imem_prog_encoder
   import LoaderPkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [1:0]        in_fmt,
   input  logic [5:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] AddrMax  = '1;

   LoaderState        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic [31:0]       r_wdata;
   logic              r_last;
   logic              r_we;
   logic              r_ready;
   logic              r_done;
   logic              r_err;
   logic              r_cpuRstN;

   logic [31:0]       w_word;
   logic              w_legal;

   instr_pack u_pack (
      .i_fmt    (in_fmt),
      .i_op     (in_op),
      .i_rs     (in_rs),
      .i_rt     (in_rt),
      .i_rd     (in_rd),
      .i_shamt  (in_shamt),
      .i_funct  (in_funct),
      .i_imm    (in_imm),
      .i_target (in_target),
      .o_word   (w_word),
      .o_legal  (w_legal)
   );

   // Output flags are registered alongside every state change so each one
   // always matches the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_addr    <= BaseAddr;
         r_count   <= '0;
         r_wdata   <= '0;
         r_last    <= 1'b0;
         r_we      <= 1'b0;
         r_ready   <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_cpuRstN <= 1'b0;
      end else begin
         case (r_state)
            StIdle, StDone, StErr: begin
               if (start) begin
                  r_state   <= StLoad;
                  r_addr    <= BaseAddr;
                  r_count   <= '0;
                  r_we      <= 1'b0;
                  r_ready   <= 1'b1;
                  r_done    <= 1'b0;
                  r_err     <= 1'b0;
                  r_cpuRstN <= 1'b0;
               end
            end
            StLoad: begin
               if (in_valid && r_ready) begin
                  r_ready <= 1'b0;
                  if (w_legal) begin
                     r_wdata <= w_word;
                     r_last  <= in_last;
                     r_we    <= 1'b1;
                     r_state <= StWrite;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= StErr;
                  end
               end
            end
            StWrite: begin
               r_we    <= 1'b0;
               r_count <= r_count + (ADDR_W+1)'(1);
               // The address saturates at all-ones; running past it without last is an overflow.
               if (r_last) begin
                  r_done    <= 1'b1;
                  r_cpuRstN <= 1'b1;
                  r_state   <= StDone;
                  if (r_addr != AddrMax) begin
                     r_addr <= r_addr + ADDR_W'(1);
                  end
               end else if (r_addr == AddrMax) begin
                  r_err   <= 1'b1;
                  r_state <= StErr;
               end else begin
                  r_addr  <= r_addr + ADDR_W'(1);
                  r_ready <= 1'b1;
                  r_state <= StLoad;
               end
            end
            default: begin
               r_state   <= StIdle;
               r_we      <= 1'b0;
               r_ready   <= 1'b0;
               r_done    <= 1'b0;
               r_err     <= 1'b0;
               r_cpuRstN <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = r_ready;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign cpu_rst_n  = r_cpuRstN;
   assign done       = r_done;
   assign err        = r_err;
   assign count      = r_count;

endmodule

// File: doc/imem_prog_encoder.md
# imem_prog_encoder

Instruction-memory program loader for the MIPS core: accepts decoded instruction fields from a host or testbench over a valid/ready stream, encodes each into a 32-bit MIPS word, and writes the words sequentially into instruction memory. It holds the CPU in reset while loading and releases it once the last word is written. It is the encoding counterpart of the opcode decoder in the single-cycle control unit: it produces only the opcodes that decoder accepts.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after `start`

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a new load at BASE_ADDR
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts fields this cycle
- in_last  in  1  current instruction is the final one
- in_fmt  in  2  format: 0 = R, 1 = I, 2 = J, 3 = reserved
- in_op  in  6  opcode
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_funct  in  6  R-type function
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- cpu_rst_n  out  1  active-low reset to the CPU core
- done  out  1  load complete
- err  out  1  sticky error flag
- count  out  ADDR_W+1  words written in the current load

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE: in_ready = 0 and cpu_rst_n = 0. `start` moves to LOAD, sets the address to BASE_ADDR and clears count.
- LOAD: in_ready = 1. On in_valid && in_ready, check the fields:
  - legal: latch the encoded word and in_last, then go to WRITE;
  - illegal: go to ERR with no write.
- Legal pairs:
  - R: op 0x00;
  - I: op 0x23 (LW), 0x2B (SW), 0x04 (BEQ), 0x08 (ADDI), 0x09 (ADDIU);
  - J: op 0x02.
  - Anything else, including fmt 3, is illegal.
- Encoding:
  - R: {op, rs, rt, rd, shamt, funct}
  - I: {op, rs, rt, imm}
  - J: {op, target}
  - Fields not used by the format are ignored.
- WRITE: imem_we = 1 for exactly one cycle, with the latched address and data. Then count increments and the address increments.
  - If the latched last = 1, go to DONE; otherwise go to LOAD.
  - If the address written was all-ones and last = 0, go to ERR (overflow; the address never wraps).
- DONE: done = 1 and cpu_rst_n = 1. `start` returns to LOAD with count and address cleared, and cpu_rst_n drops to 0 in the same edge.
- ERR: err = 1 and cpu_rst_n = 0. The flag stays set until `start`, which clears err and enters LOAD.
- `start` during LOAD or WRITE is ignored. A write in progress always completes.
- Reset (asynchronous, at any time, including mid-write): go to IDLE. Outputs:
  - imem_we = 0, in_ready = 0, done = 0, err = 0, cpu_rst_n = 0;
  - imem_addr = BASE_ADDR, imem_wdata = 0, count = 0.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from in_* to any output, except that in_ready depends on state only.
- Handshake to imem_we: 1 cycle. Throughput: one instruction every 2 cycles.
- Holding in_valid high with new fields after a handshake is legal; they are accepted on the next LOAD cycle.
- cpu_rst_n rises on the edge entering DONE, which is the cycle after the final imem_we.
- count is 0 at reset and is stable during DONE.

## Structure
- Shared package LoaderPkg holds:
  - the fmt enum (FmtR, FmtI, FmtJ);
  - the state enum.
- Opcode constants come from the existing Opcodes package. Do not duplicate them.
- One combinational sub-module, instr_pack: inputs fmt plus the fields; outputs the 32-bit word and `legal`. It is reusable by the testbench's reference model.
- The top level holds the FSM, the address/count registers and the output registers.

## Test plan
- ADDI $t0,$zero,5 (fmt I, op 0x08, rs 0, rt 8, imm 5, last 1):
  - one imem_we with addr 0 and data 0x20080005;
  - done and cpu_rst_n high one cycle later; count = 1.
- Three-word program with gaps in in_valid:
  - ADD $t2,$t0,$t1 (rs 8, rt 9, rd 10, funct 0x20) → 0x01095020 at addr 0;
  - LW $t1,4($t0) → 0x8D090004 at addr 1;
  - J target 0x100000, last → 0x08100000 at addr 2;
  - count = 3.
- Illegal input, fmt J with op 0x23:
  - no imem_we; err = 1 and cpu_rst_n = 0;
  - `start` clears err and a following legal word writes to addr 0.
- Overflow with ADDR_W = 2: five words, none with last.
  - Writes reach addr 3, then err is set on the 4th write.
  - No 5th imem_we; addr stays 3.
- Asynchronous rst_n asserted during the WRITE cycle:
  - imem_we drops immediately; state is IDLE;
  - count = 0 and all outputs take their reset values.
- `start` in DONE after a 2-word load:
  - cpu_rst_n drops on that edge and count clears;
  - a new 1-word load writes addr 0 and done reasserts.
